// File: rtl/rle_frame_scheduler.sv
// Frame scheduler for the rle core: queues frame descriptors in a small FIFO,
// launches the core once per frame, waits for done (or timeout) and reports.
module rle_frame_scheduler #(
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int GAP_CYCLES   = 10,
    parameter int TIMEOUT      = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_msg_addr,
    input  logic [31:0] desc_msg_size,
    input  logic [31:0] desc_rle_addr,
    output logic        desc_err,
    output logic        rle_start,
    output logic [31:0] rle_message_addr,
    output logic [31:0] rle_message_size,
    output logic [31:0] rle_rle_addr,
    input  logic        rle_done,
    input  logic [31:0] rle_size,
    output logic        result_valid,
    output logic [7:0]  result_id,
    output logic [31:0] result_size,
    output logic [31:0] result_latency,
    output logic        result_timeout,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] TO_LIM    = 32'(TIMEOUT);
    localparam logic [31:0] START_LIM = 32'(START_CYCLES);
    localparam logic [31:0] GAP_LIM   = 32'(GAP_CYCLES);

    typedef struct packed {
        logic [31:0] msg_addr;
        logic [31:0] msg_size;
        logic [31:0] rle_addr;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_REPORT,
        S_GAP
    } state_t;

    state_t         state_q, state_d;
    desc_t          fifo_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           ready_q, err_q;
    logic [31:0]    lat_q, lat_d, lat_inc;
    logic [31:0]    gap_q, gap_d;
    logic [31:0]    rle_maddr_q, rle_msize_q, rle_raddr_q;
    logic [7:0]     id_q, res_id_q;
    logic [31:0]    res_size_q, res_lat_q;
    logic           res_to_q;

    logic           push, aligned, wr_en, pop;
    logic           load_rle, clr_rle, cap, cap_to;
    logic [31:0]    cap_size, cap_lat;
    desc_t          head;

    assign head    = fifo_q[rd_ptr_q];
    assign push    = desc_valid && ready_q;
    assign aligned = (desc_msg_addr[1:0] == 2'b00) && (desc_rle_addr[1:0] == 2'b00);
    assign wr_en   = push && aligned;
    assign lat_inc = (lat_q == 32'hFFFF_FFFF) ? lat_q : lat_q + 32'd1;
    assign count_d = count_q + CW'(wr_en) - CW'(pop);

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        lat_d    = lat_q;
        gap_d    = gap_q;
        load_rle = 1'b0;
        clr_rle  = 1'b0;
        cap      = 1'b0;
        cap_to   = 1'b0;
        cap_size = 32'd0;
        cap_lat  = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    // Empty frames never touch the core: report straight away.
                    if (head.msg_size == 32'd0) begin
                        pop     = 1'b1;
                        cap     = 1'b1;
                        state_d = S_REPORT;
                    end else begin
                        load_rle = 1'b1;
                        lat_d    = 32'd1;
                        state_d  = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                lat_d = lat_inc;
                if (lat_q >= START_LIM) begin
                    pop     = 1'b1;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                lat_d = lat_inc;
                if (rle_done) begin
                    cap      = 1'b1;
                    cap_size = rle_size;
                    cap_lat  = lat_q;
                    clr_rle  = 1'b1;
                    state_d  = S_REPORT;
                end else if (lat_q >= TO_LIM) begin
                    cap      = 1'b1;
                    cap_to   = 1'b1;
                    cap_lat  = lat_q;
                    clr_rle  = 1'b1;
                    state_d  = S_REPORT;
                end
            end
            S_REPORT: begin
                gap_d   = 32'd1;
                state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
            end
            S_GAP: begin
                if (gap_q >= GAP_LIM) state_d = S_IDLE;
                else                  gap_d   = gap_q + 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            lat_q       <= 32'd0;
            gap_q       <= 32'd0;
            rle_maddr_q <= 32'd0;
            rle_msize_q <= 32'd0;
            rle_raddr_q <= 32'd0;
            id_q        <= 8'd0;
            res_id_q    <= 8'd0;
            res_size_q  <= 32'd0;
            res_lat_q   <= 32'd0;
            res_to_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            ready_q  <= (count_d < CW'(DEPTH));
            err_q    <= push && !aligned;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            if (load_rle) begin
                rle_maddr_q <= head.msg_addr;
                rle_msize_q <= head.msg_size;
                rle_raddr_q <= head.rle_addr;
            end else if (clr_rle) begin
                rle_maddr_q <= 32'd0;
                rle_msize_q <= 32'd0;
                rle_raddr_q <= 32'd0;
            end
            if (cap) begin
                res_id_q   <= id_q;
                id_q       <= id_q + 8'd1;
                res_size_q <= cap_size;
                res_lat_q  <= cap_lat;
                res_to_q   <= cap_to;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) fifo_q[wr_ptr_q] <= '{desc_msg_addr, desc_msg_size, desc_rle_addr};
    end

    assign desc_ready       = ready_q;
    assign desc_err         = err_q;
    assign rle_start        = (state_q == S_LAUNCH);
    assign rle_message_addr = rle_maddr_q;
    assign rle_message_size = rle_msize_q;
    assign rle_rle_addr     = rle_raddr_q;
    assign result_valid     = (state_q == S_REPORT);
    assign result_id        = res_id_q;
    assign result_size      = res_size_q;
    assign result_latency   = res_lat_q;
    assign result_timeout   = res_to_q;
    assign busy             = (state_q != S_IDLE) || (count_q != '0);

endmodule
